// File: rtl/toupper_stream_ctrl.sv
// Streaming case-conversion controller: accepts NUL-terminated strings, converts
// each byte by the mode latched at start, and buffers results in a small FIFO.
module toupper_stream_ctrl #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] char_count,
   output logic [CNT_W-1:0] conv_count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN
   } state_e;

   state_e           state_q;
   logic [1:0]       mode_q;
   logic             done_q;
   logic [CNT_W-1:0] charCount_q, charCount_d;
   logic [CNT_W-1:0] convCount_q, convCount_d;

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
   logic [PTR_W:0]   count_q;

   logic             full;
   logic             push;
   logic             pop;
   logic [7:0]       convByte;

   // Only ASCII letters are touched; toggle flips bit 5, which swaps case.
   function automatic logic [7:0] convertByte(input logic [7:0] b, input logic [1:0] m);
      logic       isUpper;
      logic       isLower;
      logic [7:0] r;
      isUpper = (b >= 8'h41) && (b <= 8'h5A);
      isLower = (b >= 8'h61) && (b <= 8'h7A);
      r = b;
      case (m)
         2'b01:   if (isLower) r = b & 8'hDF;
         2'b10:   if (isUpper) r = b | 8'h20;
         2'b11:   if (isUpper || isLower) r = b ^ 8'h20;
         default: r = b;
      endcase
      return r;
   endfunction

   assign full      = (count_q == (PTR_W+1)'(DEPTH));
   assign out_valid = (count_q != '0);
   assign in_ready  = (state_q == RUN) && !full;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign convByte  = convertByte(in_data, mode_q);
   assign out_data  = out_valid ? mem[rdPtr_q] : 8'h00;

   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign char_count = charCount_q;
   assign conv_count = convCount_q;

   assign charCount_d = (charCount_q == '1) ? charCount_q : charCount_q + CNT_W'(1);
   assign convCount_d = (convCount_q == '1) ? convCount_q : convCount_q + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mode_q      <= 2'b00;
         done_q      <= 1'b0;
         charCount_q <= '0;
         convCount_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  mode_q      <= mode;
                  charCount_q <= '0;
                  convCount_q <= '0;
                  state_q     <= RUN;
               end
            end
            RUN: begin
               if (push) begin
                  if (in_data == 8'h00) begin
                     state_q <= DRAIN;
                  end else begin
                     charCount_q <= charCount_d;
                     if (convByte != in_data) convCount_q <= convCount_d;
                  end
               end
            end
            DRAIN: begin
               // Converted letters never become 0x00, so a zero head is the terminator.
               if (pop && (out_data == 8'h00)) begin
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         if (push) wrPtr_q <= wrPtr_q + PTR_W'(1);
         if (pop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + (PTR_W+1)'(1);
            2'b01:   count_q <= count_q - (PTR_W+1)'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wrPtr_q] <= convByte;
   end

endmodule

// File: tb/tb_toupper_stream_ctrl.sv
// Randomized bench for toupper_stream_ctrl against a queue-based string model.
module tb_toupper_stream_ctrl;

   localparam int DEPTH   = 4;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic [1:0]       mode;
   logic [7:0]       in_data;
   logic             in_valid;
   logic             in_ready;
   logic [7:0]       out_data;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] char_count;
   logic [CNT_W-1:0] conv_count;

   int checks   = 0;
   int failures = 0;

   logic [7:0] expQ[$];
   int         expPhase;
   logic [1:0] expMode;
   int         expChar;
   int         expConv;
   logic       expDone;
   logic       lastAccept;
   logic       lastDone;

   toupper_stream_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .mode       (mode),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .busy       (busy),
      .done       (done),
      .char_count (char_count),
      .conv_count (conv_count)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] refConvert(input logic [7:0] b, input logic [1:0] m);
      int v;
      bit up;
      bit lo;
      v  = int'(b);
      up = (v >= 65) && (v <= 90);
      lo = (v >= 97) && (v <= 122);
      case (m)
         2'd1: if (lo) v = v - 32;
         2'd2: if (up) v = v + 32;
         2'd3: if (lo) v = v - 32; else if (up) v = v + 32;
         default: ;
      endcase
      return 8'(v);
   endfunction

   // Entered one unit after a rising edge; checks mid-cycle, then advances the model.
   task automatic runCycle();
      int         occ;
      int         prePhase;
      logic       expInReady;
      logic       expOutValid;
      logic       acc;
      logic       pp;
      logic [7:0] head;
      logic [7:0] conv;
      #3;
      occ         = expQ.size();
      prePhase    = expPhase;
      expInReady  = (prePhase == 1) && (occ < DEPTH);
      expOutValid = (occ > 0);
      checkOutput("in_ready", 32'(in_ready), 32'(expInReady));
      checkOutput("out_valid", 32'(out_valid), 32'(expOutValid));
      if (expOutValid) checkOutput("out_data", 32'(out_data), 32'(expQ[0]));
      checkOutput("busy", 32'(busy), 32'(prePhase != 0));
      checkOutput("done", 32'(done), 32'(expDone));
      checkOutput("char_count", 32'(char_count), 32'(expChar));
      checkOutput("conv_count", 32'(conv_count), 32'(expConv));

      acc     = in_valid && expInReady;
      pp      = expOutValid && out_ready;
      head    = expOutValid ? expQ[0] : 8'h00;
      expDone = 1'b0;
      if (prePhase == 0 && start) begin
         expMode  = mode;
         expChar  = 0;
         expConv  = 0;
         expPhase = 1;
      end else if (prePhase == 1 && acc) begin
         conv = refConvert(in_data, expMode);
         expQ.push_back(conv);
         if (in_data == 8'h00) begin
            expPhase = 2;
         end else begin
            if (expChar < CNT_MAX) expChar++;
            if (conv != in_data && expConv < CNT_MAX) expConv++;
         end
      end
      if (pp) begin
         void'(expQ.pop_front());
         if (prePhase == 2 && head == 8'h00) begin
            expPhase = 0;
            expDone  = 1'b1;
         end
      end
      lastAccept = acc;
      lastDone   = expDone;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [1:0] m, input logic [7:0] str[$],
                                input int readyPct, input int holdCycles, input bit noise);
      int idx;
      int cyc;
      bit finished;
      idx      = 0;
      cyc      = 0;
      finished = 0;
      start    = 1'b1;
      mode     = m;
      in_valid = 1'b0;
      out_ready = 1'b0;
      runCycle();
      start = 1'b0;
      while (!finished && cyc < 600) begin
         if (idx < str.size()) begin
            in_valid = noise ? ($urandom_range(3) != 0) : 1'b1;
            in_data  = str[idx];
         end else begin
            in_valid = noise ? 1'($urandom_range(1)) : 1'b0;
            in_data  = 8'($urandom_range(255));
         end
         out_ready = (cyc < holdCycles) ? 1'b0 : ($urandom_range(99) < readyPct);
         if (noise) begin
            mode  = 2'($urandom_range(3));
            start = ($urandom_range(7) == 0);
         end
         runCycle();
         cyc++;
         if (lastAccept) idx++;
         if (lastDone) finished = 1;
      end
      start    = 1'b0;
      in_valid = 1'b0;
      if (!finished) checkOutput("string_timeout", 32'd0, 32'd1);
   endtask

   task automatic resetMidString();
      start = 1'b1;
      mode  = 2'b01;
      out_ready = 1'b0;
      runCycle();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1;
         in_data  = 8'(8'h61 + i);
         runCycle();
      end
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      checkOutput("rst_char_count", 32'(char_count), 32'd0);
      checkOutput("rst_conv_count", 32'(conv_count), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'd0);
      expQ.delete();
      expPhase = 0;
      expMode  = 2'b00;
      expChar  = 0;
      expConv  = 0;
      expDone  = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid  = 1'b1;
         in_data   = 8'h41;
         out_ready = 1'b1;
         runCycle();
      end
      in_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] s[$];
      rst       = 1'b1;
      start     = 1'b0;
      mode      = 2'b00;
      in_data   = 8'h00;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      expPhase  = 0;
      expMode   = 2'b00;
      expChar   = 0;
      expConv   = 0;
      expDone   = 1'b0;
      @(posedge clk);
      #3;
      checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_out_data", 32'(out_data), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_char_count", 32'(char_count), 32'd0);
      checkOutput("reset_conv_count", 32'(conv_count), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      s = '{8'h61, 8'h7A, 8'h7B, 8'h00};
      applyStimulus(2'b01, s, 100, 0, 1'b0);
      s = '{8'h48, 8'h69, 8'h40, 8'h5B, 8'h00};
      applyStimulus(2'b11, s, 100, 0, 1'b0);
      s = '{8'h41, 8'h60, 8'h00};
      applyStimulus(2'b10, s, 100, 0, 1'b0);
      s = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h00};
      applyStimulus(2'b01, s, 100, 8, 1'b0);
      s = '{8'h61, 8'hE1, 8'h00};
      applyStimulus(2'b00, s, 100, 0, 1'b1);

      resetMidString();

      s = '{8'h68, 8'h69, 8'h00};
      applyStimulus(2'b01, s, 100, 0, 1'b0);
      s = '{8'h6F, 8'h4B, 8'h21, 8'h00};
      applyStimulus(2'b01, s, 100, 0, 1'b0);

      s.delete();
      for (int i = 0; i < 20; i++) s.push_back(8'h61);
      s.push_back(8'h00);
      applyStimulus(2'b01, s, 100, 0, 1'b0);

      for (int n = 0; n < 12; n++) begin
         int len;
         len = $urandom_range(12);
         s.delete();
         for (int i = 0; i < len; i++) s.push_back(8'($urandom_range(255, 1)));
         s.push_back(8'h00);
         applyStimulus(2'($urandom_range(3)), s, $urandom_range(100, 30), $urandom_range(6), 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/toupper_stream_ctrl.md
Name: toupper_stream_ctrl

Overview:
- Streaming controller that sequences NUL-terminated byte strings through the team's 8-bit ASCII case-conversion datapath.
- Accepts bytes over a valid/ready input and applies the mode latched at start: pass, upper, lower or toggle case.
- Buffers converted bytes in a small FIFO and emits them over a valid/ready output.
- Counts processed and converted characters and pulses done when the whole string has drained.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2.
CNT_W, 16, width of the character counters.

Ports:
clk  in  1  system clock, rising-edge.
rst  in  1  asynchronous, active-high reset.
start  in  1  begin a string; sampled only in IDLE.
mode  in  2  00 pass, 01 to-upper, 10 to-lower, 11 toggle case; latched at start.
in_data  in  8  input ASCII byte.
in_valid  in  1  in_data valid.
in_ready  out  1  controller can accept a byte.
out_data  out  8  converted byte at FIFO head.
out_valid  out  1  out_data valid.
out_ready  in  1  sink accepts out_data.
busy  out  1  state is not IDLE.
done  out  1  one-cycle pulse when the string has fully drained.
char_count  out  CNT_W  bytes accepted, excluding the NUL terminator.
conv_count  out  CNT_W  accepted bytes whose value was changed by conversion.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE; FIFO emptied (pointers and count cleared).
  - in_ready=0, out_valid=0, out_data=0x00, busy=0, done=0.
  - char_count=0, conv_count=0, latched mode=00.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE: start=1 latches mode, clears both counters and moves to RUN next edge. done stays 0.
  - RUN: in_ready = !full. A byte is accepted when in_valid && in_ready.
    - Accepted byte != 0x00: converted byte is written to the FIFO; char_count +1; conv_count +1 if converted != original.
    - Accepted byte == 0x00: NUL is written to the FIFO unchanged, no counter change, state -> DRAIN.
  - DRAIN: in_ready=0. The NUL pop is out_valid && out_ready with a 0x00 head entry; the FIFO is then empty. On that edge done is registered high and state -> IDLE, so done is high for exactly the following cycle.
- Handshake and latency:
  - out_valid = FIFO not empty. Pop occurs when out_valid && out_ready.
  - A byte accepted at edge N is visible on out_data and out_valid after edge N (one-cycle latency into an empty FIFO).
  - Order is strictly preserved.
  - Full FIFO: in_ready=0 even if a pop happens in the same cycle (no bypass).
  - Empty FIFO: no read of stale data; out_data is don't-care while out_valid=0.
  - Simultaneous push and pop when neither full nor empty: both occur and the count is unchanged.
  - Pointers wrap modulo DEPTH.
- Conversion rules (only letters 0x41-0x5A and 0x61-0x7A are touched; all other bytes, including 0x40, 0x5B, 0x60, 0x7B and bytes >= 0x80, pass unchanged):
  - Mode 01: 0x61-0x7A minus 0x20.
  - Mode 10: 0x41-0x5A plus 0x20.
  - Mode 11: bit 5 is inverted for letters.
- Counters saturate at 2^CNT_W-1 and hold their value after done until the next start.
- Ignored inputs:
  - start outside IDLE is ignored.
  - Changing mode outside the start cycle has no effect.
  - in_valid in IDLE or DRAIN is ignored (in_ready=0).
- Reset mid-string discards all buffered data. No done pulse is generated. in_ready stays 0 until the next start.

Test Plan:
- Mode 01, out_ready=1, send 0x61,0x7A,0x7B,0x00: out 0x41,0x5A,0x7B,0x00, each one cycle after acceptance; char_count=3, conv_count=2; done high one cycle after the NUL pop, then busy=0.
- Mode 11, send 0x48,0x69,0x40,0x5B,0x00: out 0x68,0x49,0x40,0x5B,0x00; conv_count=2. Mode 10, send 0x41,0x60: out 0x61,0x60.
- DEPTH=4, out_ready=0, offer 6 bytes: in_ready drops after 4 accepts. Raise out_ready: all 6 bytes emerge in order, and in_ready reasserts the cycle after the first pop.
- Mode 00, send 0x61,0xE1,0x00: out unchanged; conv_count=0, char_count=2. Toggling mode to 01 mid-string and pulsing start during RUN both have no effect.
- 3 bytes buffered, assert rst asynchronously: out_valid, busy and counters read 0 before the next clk edge; no done pulse; after release in_ready=0 until start.
- Back-to-back strings: start in the cycle after done with mode 01; the second string converts correctly and the counters restart from 0.
